// File: rtl/timer_pwm.sv
// Prescaled 32-bit timer with two shadowed PWM compare channels and a level IRQ.
// Optional input capture is built when TIMER_PWM_CAPTURE_EN is defined.
module timer_pwm #(
  parameter int PRESC_W = 16,
  parameter int CH_NUM  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        waddr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  input  logic [7:0]        raddr_i,
  input  logic              rd_i,
`ifdef TIMER_PWM_CAPTURE_EN
  input  logic              capt_i,
`endif
  output logic [31:0]       data_o,
  output logic [CH_NUM-1:0] pwm_o,
  output logic              irq_timer_o
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PRESC  = 8'h04;
  localparam logic [7:0] A_PERIOD = 8'h08;
  localparam logic [7:0] A_CMP0   = 8'h0C;
  localparam logic [7:0] A_CNT    = 8'h14;
  localparam logic [7:0] A_STATUS = 8'h18;
`ifdef TIMER_PWM_CAPTURE_EN
  localparam logic [7:0] A_CAPT   = 8'h1C;
  localparam logic [7:0] CTRL_MASK   = 8'hFF;
  localparam logic [3:0] STATUS_MASK = 4'hF;
`else
  localparam logic [7:0] CTRL_MASK   = 8'h7F;
  localparam logic [3:0] STATUS_MASK = 4'h7;
`endif

  logic [7:0]         ctrl;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] psc_cnt;
  logic [31:0]        period_sh;
  logic [31:0]        period_act;
  logic [31:0]        cmp_sh  [CH_NUM];
  logic [31:0]        cmp_act [CH_NUM];
  logic [31:0]        cnt;
  logic [3:0]         status;

  logic               en;
  logic               oneshot;
  logic [CH_NUM-1:0]  pol;
  logic [31:0]        wmask;
  logic               wr_ctrl, wr_presc, wr_period, wr_cnt, wr_status;
  logic [CH_NUM-1:0]  wr_cmp;
  logic               tick, wrap, reload;
  logic [CH_NUM-1:0]  cmp_hit;
  logic               capt_edge;
  logic [3:0]         status_set, status_clr;
  logic [31:0]        rd_data;

  assign en      = ctrl[0];
  assign oneshot = ctrl[1];
  assign pol     = ctrl[5 +: CH_NUM];
  assign wmask   = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  always_comb begin
    wr_ctrl   = we_i && (waddr_i == A_CTRL);
    wr_presc  = we_i && (waddr_i == A_PRESC);
    wr_period = we_i && (waddr_i == A_PERIOD);
    wr_cnt    = we_i && (waddr_i == A_CNT);
    wr_status = we_i && (waddr_i == A_STATUS);
    for (int x = 0; x < CH_NUM; x++) begin
      wr_cmp[x] = we_i && (waddr_i == A_CMP0 + 8'(4 * x));
    end
  end

  // ">=" keeps the prescaler from running away if PRESC is lowered mid-count.
  // A CNT write on a tick cycle overrides the tick entirely.
  always_comb begin
    tick   = en && (psc_cnt >= presc);
    wrap   = tick && !wr_cnt && (cnt == period_act);
    reload = wrap || !en;
    for (int x = 0; x < CH_NUM; x++) begin
      cmp_hit[x] = tick && !wr_cnt &&
                   ((cnt + 32'd1 == cmp_act[x]) || (wrap && (cmp_act[x] == 32'd0)));
    end
    status_set = {capt_edge, cmp_hit, wrap};
    status_clr = (wr_status && sel_i[0]) ? (data_i[3:0] & STATUS_MASK) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl        <= '0;
      presc       <= '0;
      psc_cnt     <= '0;
      period_sh   <= '0;
      period_act  <= '0;
      cnt         <= '0;
      status      <= '0;
      pwm_o       <= '0;
      irq_timer_o <= 1'b0;
      for (int x = 0; x < CH_NUM; x++) begin
        cmp_sh[x]  <= '0;
        cmp_act[x] <= '0;
      end
    end else begin
      if (wr_ctrl && sel_i[0]) begin
        ctrl <= data_i[7:0] & CTRL_MASK;
      end else if (wrap && oneshot) begin
        ctrl[0] <= 1'b0;
      end

      if (wr_presc) begin
        presc <= (presc & ~wmask[PRESC_W-1:0]) | (data_i[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
      end

      if (!en || tick) psc_cnt <= '0;
      else             psc_cnt <= psc_cnt + 1'b1;

      if (wr_period) period_sh <= (period_sh & ~wmask) | (data_i & wmask);
      for (int x = 0; x < CH_NUM; x++) begin
        if (wr_cmp[x]) cmp_sh[x] <= (cmp_sh[x] & ~wmask) | (data_i & wmask);
      end

      // Active copies track the shadows while stopped, otherwise only at wrap.
      if (reload) begin
        period_act <= period_sh;
        for (int x = 0; x < CH_NUM; x++) cmp_act[x] <= cmp_sh[x];
      end

      if (wr_cnt)       cnt <= (cnt & ~wmask) | (data_i & wmask);
      else if (wrap)    cnt <= '0;
      else if (tick)    cnt <= cnt + 32'd1;

      status <= (status & ~status_clr) | status_set;

      for (int x = 0; x < CH_NUM; x++) begin
        pwm_o[x] <= en ? ((cnt < cmp_act[x]) ^ pol[x]) : pol[x];
      end

      irq_timer_o <= |(status & {ctrl[7], ctrl[4:2]});
    end
  end

`ifdef TIMER_PWM_CAPTURE_EN
  logic        capt_s1, capt_s2, capt_s3;
  logic [31:0] capt;

  assign capt_edge = capt_s2 & ~capt_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capt_s1 <= 1'b0;
      capt_s2 <= 1'b0;
      capt_s3 <= 1'b0;
      capt    <= '0;
    end else begin
      capt_s1 <= capt_i;
      capt_s2 <= capt_s1;
      capt_s3 <= capt_s2;
      if (capt_edge) capt <= cnt;
    end
  end
`else
  assign capt_edge = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (raddr_i)
      A_CTRL:   rd_data = {24'd0, ctrl};
      A_PRESC:  rd_data = 32'(presc);
      A_PERIOD: rd_data = period_sh;
      A_CNT:    rd_data = cnt;
      A_STATUS: rd_data = {28'd0, status};
`ifdef TIMER_PWM_CAPTURE_EN
      A_CAPT:   rd_data = capt;
`endif
      default:  rd_data = '0;
    endcase
    for (int x = 0; x < CH_NUM; x++) begin
      if (raddr_i == A_CMP0 + 8'(4 * x)) rd_data = cmp_sh[x];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_o <= '0;
    else if (rd_i) data_o <= rd_data;
  end

endmodule

// File: tb/tb_timer_pwm.sv
// Directed bench for timer_pwm: registers, counting, PWM, shadows, one-shot, collisions.
// Build with TIMER_PWM_CAPTURE_EN defined to also exercise input capture.
module tb_timer_pwm;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PRESC  = 8'h04;
  localparam logic [7:0] A_PERIOD = 8'h08;
  localparam logic [7:0] A_CMP0   = 8'h0C;
  localparam logic [7:0] A_CMP1   = 8'h10;
  localparam logic [7:0] A_CNT    = 8'h14;
  localparam logic [7:0] A_STATUS = 8'h18;
  localparam logic [7:0] A_CAPT   = 8'h1C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  waddr_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  sel_i = '0;
  logic        we_i = 1'b0;
  logic [7:0]  raddr_i = '0;
  logic        rd_i = 1'b0;
  logic        capt_i = 1'b0;
  logic [31:0] data_o;
  logic [1:0]  pwm_o;
  logic        irq_timer_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_pwm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .waddr_i    (waddr_i),
    .data_i     (data_i),
    .sel_i      (sel_i),
    .we_i       (we_i),
    .raddr_i    (raddr_i),
    .rd_i       (rd_i),
`ifdef TIMER_PWM_CAPTURE_EN
    .capt_i     (capt_i),
`endif
    .data_o     (data_o),
    .pwm_o      (pwm_o),
    .irq_timer_o(irq_timer_o)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr_i = a; data_i = d; sel_i = s; we_i = 1'b1;
    idle(1);
    we_i = 1'b0; sel_i = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    raddr_i = a; rd_i = 1'b1;
    idle(1);
    rd_i = 1'b0;
    d = data_o;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we_i = 1'b0; rd_i = 1'b0; capt_i = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [7:0]  addrs [8];
    logic [31:0] exp_ctrl;
    addrs = '{A_CTRL, A_PRESC, A_PERIOD, A_CMP0, A_CMP1, A_CNT, A_STATUS, A_CAPT};
    do_reset();
    total++; if (data_o !== 32'd0) begin bad++; $display("FAIL reset_data_o got=%h exp=0", data_o); end
    total++; if (pwm_o !== 2'b00) begin bad++; $display("FAIL reset_pwm got=%b exp=00", pwm_o); end
    total++; if (irq_timer_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_timer_o); end
    for (int i = 0; i < 8; i++) begin
      rd(addrs[i], d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_reg_%h got=%h exp=0", addrs[i], d); end
    end
    wr(8'h20, 32'hDEAD_BEEF, 4'hF);
    rd(8'h20, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
    wr(A_CTRL, 32'h80, 4'h1);
`ifdef TIMER_PWM_CAPTURE_EN
    exp_ctrl = 32'h80;
`else
    exp_ctrl = 32'h00;
`endif
    rd(A_CTRL, d);
    total++; if (d !== exp_ctrl) begin bad++; $display("FAIL ctrl_bit7 got=%h exp=%h", d, exp_ctrl); end
  endtask

  task automatic test_count();
    logic [31:0] d;
    logic [31:0] exp_cnt [9];
    exp_cnt = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    wr(A_PRESC, 32'd1, 4'hF);
    wr(A_PERIOD, 32'd3, 4'hF);
    wr(A_CTRL, 32'h05, 4'hF);
    raddr_i = A_CNT; rd_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      idle(1);
      total++; if (data_o !== exp_cnt[k-1]) begin bad++; $display("FAIL count_cnt_k%0d got=%0d exp=%0d", k, data_o, exp_cnt[k-1]); end
      total++; if (irq_timer_o !== (k >= 9)) begin bad++; $display("FAIL count_irq_k%0d got=%b exp=%b", k, irq_timer_o, (k >= 9)); end
    end
    rd_i = 1'b0;
    rd(A_STATUS, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL count_status got=%h exp=7", d); end
    wr(A_STATUS, 32'h1, 4'h1);
    idle(1);
    total++; if (irq_timer_o !== 1'b0) begin bad++; $display("FAIL count_irq_clear got=%b exp=0", irq_timer_o); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL count_status_w1c got=%h exp=6", d); end
    wr(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_pwm();
    int hi0, hi1;
    logic exp_bit;
    do_reset();
    wr(A_PERIOD, 32'd9, 4'hF);
    wr(A_CMP0, 32'd3, 4'hF);
    wr(A_CTRL, 32'h01, 4'hF);
    hi0 = 0; hi1 = 0;
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      exp_bit = (((k - 1) % 10) < 3);
      total++; if (pwm_o[0] !== exp_bit) begin bad++; $display("FAIL pwm_wave_k%0d got=%b exp=%b", k, pwm_o[0], exp_bit); end
      hi0 += int'(pwm_o[0]);
      hi1 += int'(pwm_o[1]);
    end
    total++; if (hi0 != 6) begin bad++; $display("FAIL pwm_duty30 got=%0d exp=6", hi0); end
    total++; if (hi1 != 0) begin bad++; $display("FAIL pwm_ch1_zero got=%0d exp=0", hi1); end

    wr(A_CTRL, 32'h21, 4'hF);
    hi0 = 0;
    for (int k = 0; k < 20; k++) begin idle(1); hi0 += int'(pwm_o[0]); end
    total++; if (hi0 != 14) begin bad++; $display("FAIL pwm_pol_inv got=%0d exp=14", hi0); end

    wr(A_CTRL, 32'h01, 4'hF);
    wr(A_CMP0, 32'd0, 4'hF);
    idle(12);
    hi0 = 0;
    for (int k = 0; k < 20; k++) begin idle(1); hi0 += int'(pwm_o[0]); end
    total++; if (hi0 != 0) begin bad++; $display("FAIL pwm_cmp0_zero got=%0d exp=0", hi0); end

    wr(A_CMP0, 32'd12, 4'hF);
    idle(12);
    hi0 = 0;
    for (int k = 0; k < 20; k++) begin idle(1); hi0 += int'(pwm_o[0]); end
    total++; if (hi0 != 20) begin bad++; $display("FAIL pwm_cmp0_full got=%0d exp=20", hi0); end
    wr(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_shadow();
    logic [31:0] d;
    int m, exp_v;
    do_reset();
    wr(A_PERIOD, 32'd9, 4'hF);
    wr(A_CTRL, 32'h01, 4'hF);
    wr(A_PERIOD, 32'd19, 4'hF);
    rd(A_PERIOD, d);
    total++; if (d !== 32'd19) begin bad++; $display("FAIL shadow_read got=%0d exp=19", d); end
    raddr_i = A_CNT; rd_i = 1'b1;
    for (int k = 3; k <= 32; k++) begin
      idle(1);
      m = k - 1;
      exp_v = (m <= 9) ? m : ((m - 10) % 20);
      total++; if (data_o !== 32'(exp_v)) begin bad++; $display("FAIL shadow_cnt_k%0d got=%0d exp=%0d", k, data_o, exp_v); end
    end
    rd_i = 1'b0;
    wr(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    wr(A_PERIOD, 32'd4, 4'hF);
    wr(A_CTRL, 32'h23, 4'hF);
    idle(10);
    rd(A_STATUS, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL oneshot_status got=%h exp=7", d); end
    wr(A_STATUS, 32'h7, 4'h1);
    idle(10);
    rd(A_STATUS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_single_ovf got=%h exp=0", d); end
    rd(A_CTRL, d);
    total++; if (d !== 32'h22) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=22", d); end
    rd(A_CNT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_cnt got=%0d exp=0", d); end
    total++; if (pwm_o !== 2'b01) begin bad++; $display("FAIL oneshot_pwm got=%b exp=01", pwm_o); end
  endtask

  task automatic test_collide();
    logic [31:0] d;
    do_reset();
    wr(A_PERIOD, 32'd4, 4'hF);
    wr(A_CTRL, 32'h01, 4'hF);
    idle(9);
    wr(A_STATUS, 32'h1, 4'h1);
    rd(A_STATUS, d);
    total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL collide_w1c_set got=%b exp=1", d[0]); end
    idle(3);
    wr(A_CNT, 32'd7, 4'hF);
    rd(A_CNT, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL collide_cnt_write got=%0d exp=7", d); end
    rd(A_CNT, d);
    total++; if (d !== 32'd8) begin bad++; $display("FAIL collide_cnt_next got=%0d exp=8", d); end
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_PERIOD, 32'hAABB_CCDD, 4'b0010);
    rd(A_PERIOD, d);
    total++; if (d !== 32'h0000_CC04) begin bad++; $display("FAIL bytemask_period got=%h exp=0000cc04", d); end
    wr(A_PRESC, 32'h1234_5678, 4'hF);
    rd(A_PRESC, d);
    total++; if (d !== 32'h0000_5678) begin bad++; $display("FAIL presc_width got=%h exp=00005678", d); end
  endtask

  task automatic test_period0_async_reset();
    logic [31:0] d;
    do_reset();
    wr(A_CTRL, 32'h65, 4'hF);
    rd(A_CNT, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL period0_cnt_a got=%0d exp=0", d); end
    rd(A_CNT, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL period0_cnt_b got=%0d exp=0", d); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h7) begin bad++; $display("FAIL period0_status got=%h exp=7", d); end
    total++; if (irq_timer_o !== 1'b1) begin bad++; $display("FAIL period0_irq got=%b exp=1", irq_timer_o); end
    total++; if (pwm_o !== 2'b11) begin bad++; $display("FAIL period0_pwm got=%b exp=11", pwm_o); end
    rst_n = 1'b0;
    #1;
    total++; if (data_o !== 32'd0) begin bad++; $display("FAIL async_rst_data got=%h exp=0", data_o); end
    total++; if (pwm_o !== 2'b00) begin bad++; $display("FAIL async_rst_pwm got=%b exp=00", pwm_o); end
    total++; if (irq_timer_o !== 1'b0) begin bad++; $display("FAIL async_rst_irq got=%b exp=0", irq_timer_o); end
    idle(1);
    rst_n = 1'b1;
    idle(1);
    rd(A_CTRL, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL async_rst_ctrl got=%h exp=0", d); end
  endtask

`ifdef TIMER_PWM_CAPTURE_EN
  task automatic test_capture();
    logic [31:0] d;
    do_reset();
    wr(A_PRESC, 32'd3, 4'hF);
    wr(A_PERIOD, 32'd100, 4'hF);
    wr(A_CTRL, 32'h81, 4'hF);
    idle(19);
    capt_i = 1'b1;
    idle(2);
    capt_i = 1'b0;
    idle(1);
    total++; if (irq_timer_o !== 1'b0) begin bad++; $display("FAIL capt_irq_early got=%b exp=0", irq_timer_o); end
    rd(A_CAPT, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL capt_value got=%0d exp=5", d); end
    total++; if (irq_timer_o !== 1'b1) begin bad++; $display("FAIL capt_irq got=%b exp=1", irq_timer_o); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL capt_status got=%h exp=8", d); end
    wr(A_CTRL, 32'h0, 4'hF);
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_pwm();
    test_shadow();
    test_oneshot();
    test_collide();
    test_period0_async_reset();
`ifdef TIMER_PWM_CAPTURE_EN
    test_capture();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
